// File: rtl/palette_selector_if.sv
// Palette selector bus: menu/button controls, pixel stream, palette write port
// and the selector outputs.
interface palette_selector_if;
  logic        menu_en;
  logic        btn_next;
  logic        btn_prev;
  logic [12:0] pixel_index;
  logic [15:0] curr_pixel_oled;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] oled_data;
  logic [15:0] selected_colour;
  logic [3:0]  sel_idx;
  logic        busy;

  modport master (
    output menu_en, btn_next, btn_prev, pixel_index, curr_pixel_oled,
           wr_en, wr_addr, wr_data,
    input  oled_data, selected_colour, sel_idx, busy
  );

  modport slave (
    input  menu_en, btn_next, btn_prev, pixel_index, curr_pixel_oled,
           wr_en, wr_addr, wr_data,
    output oled_data, selected_colour, sel_idx, busy
  );
endinterface

// File: rtl/palette_selector.sv
// Colour-palette selector: writable RGB565 palette, cursor with hold-off
// lockout, and a swatch-strip overlay on the OLED pixel stream.
// Optional macro PALSEL_WRAP_EN: cursor wraps at the ends instead of saturating.
//
// state | meaning
// IDLE  | move requests accepted
// LOCK  | hold-off running, buttons ignored
module palette_selector #(
  parameter int N_COLOURS = 13,
  parameter int HOLDOFF   = 25_000_000,
  parameter int STRIP_Y   = 54
) (
  input logic               CLOCK,
  input logic               RESETN,
  palette_selector_if.slave bus
);

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  function automatic logic [15:0] pal_init(input int i);
    case (i)
      0:       return 16'h0000;
      1:       return 16'hFED3;
      2:       return 16'hFD46;
      3:       return 16'hC240;
      4:       return 16'hF800;
      5:       return 16'hCB5D;
      6:       return 16'h1619;
      7:       return 16'h2B58;
      8:       return 16'h0C8A;
      9:       return 16'h7687;
      10:      return 16'hFFCB;
      11:      return 16'h7BEF;
      default: return 16'hC618;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sel_q, sel_d;
  logic            busy_q, busy_d;
  logic [15:0]     oled_q, oled_d;
  logic [15:0]     pal_q [N_COLOURS];
  logic [15:0]     pal_d [N_COLOURS];
  logic            move;
  logic [15:0]     sel_colour;
  logic [6:0]      x, y;
  int              xi, yi, cx;
  logic            in_strip;

  // Cursor FSM next state: accept one-button moves in IDLE, count out the lockout in LOCK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    move    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.menu_en && (bus.btn_next ^ bus.btn_prev)) begin
          if (bus.btn_next) begin
            if (sel_q != 4'(N_COLOURS - 1)) begin
              sel_d = sel_q + 4'd1;
              move  = 1'b1;
            end
`ifdef PALSEL_WRAP_EN
            else begin
              sel_d = 4'd0;
              move  = 1'b1;
            end
`endif
          end else begin
            if (sel_q != 4'd0) begin
              sel_d = sel_q - 4'd1;
              move  = 1'b1;
            end
`ifdef PALSEL_WRAP_EN
            else begin
              sel_d = 4'(N_COLOURS - 1);
              move  = 1'b1;
            end
`endif
          end
        end
        if (move) begin
          state_d = LOCK;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (cnt_q == CW'(HOLDOFF - 1)) state_d = IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
    endcase
    busy_d = (state_d == LOCK);
  end

  // Palette write port; out-of-range addresses match no entry and are dropped.
  always_comb begin
    pal_d = pal_q;
    if (bus.wr_en) begin
      for (int i = 0; i < N_COLOURS; i++) begin
        if (bus.wr_addr == 4'(i)) pal_d[i] = bus.wr_data;
      end
    end
  end

  // Colour under the cursor, muxed from the palette registers.
  always_comb begin
    sel_colour = '0;
    for (int i = 0; i < N_COLOURS; i++) begin
      if (sel_q == 4'(i)) sel_colour = pal_q[i];
    end
  end

  // Overlay: border, then selected box outline, then swatches, else canvas pixel.
  // Swatches read the current palette registers, so a same-cycle write shows next cycle.
  always_comb begin
    x        = 7'(bus.pixel_index % 13'd96);
    y        = 7'(bus.pixel_index / 13'd96);
    xi       = int'(x);
    yi       = int'(y);
    cx       = 3 + 7 * int'(sel_q);
    in_strip = (yi >= STRIP_Y) && (yi <= STRIP_Y + 9);
    oled_d   = bus.curr_pixel_oled;
    if (bus.menu_en && in_strip) begin
      if (xi == 0 || xi == 95 || yi == STRIP_Y || yi == STRIP_Y + 9) begin
        oled_d = 16'h0000;
      end else if (((yi == STRIP_Y + 2 || yi == STRIP_Y + 7) && xi >= cx && xi <= cx + 5) ||
                   ((xi == cx || xi == cx + 5) && yi >= STRIP_Y + 2 && yi <= STRIP_Y + 7)) begin
        oled_d = 16'hF800;
      end else if (yi == STRIP_Y + 4 || yi == STRIP_Y + 5) begin
        for (int i = 0; i < N_COLOURS; i++) begin
          if (xi == 5 + 7 * i || xi == 6 + 7 * i) oled_d = pal_q[i];
        end
      end
    end
  end

  // All state registers; reset also aborts any lockout in progress.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      oled_q  <= '0;
      for (int i = 0; i < N_COLOURS; i++) pal_q[i] <= pal_init(i);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      oled_q  <= oled_d;
      pal_q   <= pal_d;
    end
  end

  assign bus.oled_data       = oled_q;
  assign bus.selected_colour = sel_colour;
  assign bus.sel_idx         = sel_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_palette_selector.sv
// Directed bench for palette_selector (N_COLOURS=13, HOLDOFF=4, STRIP_Y=54).
module tb_palette_selector;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  palette_selector_if bus ();

  palette_selector #(.N_COLOURS(13), .HOLDOFF(4), .STRIP_Y(54)) dut (
    .CLOCK (clk),
    .RESETN(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_sel;
    logic       exp_busy;
    rstn = 1'b0;
    tick();
    tick();
    vectors++; if (bus.sel_idx !== 4'd0) begin miscompares++; $display("FAIL reset_sel got %h want 0", bus.sel_idx); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.oled_data !== 16'h0000) begin miscompares++; $display("FAIL reset_oled got %h want 0000", bus.oled_data); end
    vectors++; if (bus.selected_colour !== 16'h0000) begin miscompares++; $display("FAIL reset_selcol got %h want 0000", bus.selected_colour); end
    // prev at index 0
    rstn = 1'b1;
    bus.menu_en  = 1'b1;
    bus.btn_prev = 1'b1;
    tick();
    bus.btn_prev = 1'b0;
`ifdef PALSEL_WRAP_EN
    exp_sel = 4'd12; exp_busy = 1'b1;
`else
    exp_sel = 4'd0;  exp_busy = 1'b0;
`endif
    vectors++; if (bus.sel_idx !== exp_sel) begin miscompares++; $display("FAIL prev_at_0_sel got %h want %h", bus.sel_idx, exp_sel); end
    vectors++; if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL prev_at_0_busy got %b want %b", bus.busy, exp_busy); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_hold_repeat();
    logic [3:0] exp_sel;
    logic       exp_busy;
    bus.menu_en  = 1'b1;
    bus.btn_next = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_sel  = 4'((k >= 1) + (k >= 6) + (k >= 11));
      exp_busy = (k != 5) && (k != 10);
      vectors++; if (bus.sel_idx !== exp_sel) begin miscompares++; $display("FAIL hold_sel k=%0d got %h want %h", k, bus.sel_idx, exp_sel); end
      vectors++; if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL hold_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
    end
    bus.btn_next = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_both_buttons();
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (bus.sel_idx !== 4'd3) begin miscompares++; $display("FAIL both_sel got %h want 3", bus.sel_idx); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL both_busy got %b want 0", bus.busy); end
    end
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
  endtask

  task automatic test_write();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hABCD;
    tick();
    bus.wr_en = 1'b0;
    vectors++; if (bus.selected_colour !== 16'hABCD) begin miscompares++; $display("FAIL write_selcol got %h want abcd", bus.selected_colour); end
    bus.wr_en = 1'b1; bus.wr_addr = 4'd13; bus.wr_data = 16'h1234;
    tick();
    bus.wr_en = 1'b0;
    vectors++; if (bus.selected_colour !== 16'hABCD) begin miscompares++; $display("FAIL write_oob_selcol got %h want abcd", bus.selected_colour); end
    bus.btn_prev = 1'b1;
    tick();
    bus.btn_prev = 1'b0;
    vectors++; if (bus.sel_idx !== 4'd2) begin miscompares++; $display("FAIL prev_sel got %h want 2", bus.sel_idx); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL prev_busy got %b want 1", bus.busy); end
    vectors++; if (bus.selected_colour !== 16'hFD46) begin miscompares++; $display("FAIL prev_selcol got %h want fd46", bus.selected_colour); end
    repeat (3) tick();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL lock_len_busy3 got %b want 1", bus.busy); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL lock_len_busy4 got %b want 0", bus.busy); end
  endtask

  task automatic test_overlay();
    logic [12:0] pix   [14];
    logic [15:0] exp_o [14];
    pix = '{13'(58*96+19), 13'(56*96+17), 13'(54*96+40), 13'(10*96+10),
            13'(63*96+50), 13'(60*96+0),  13'(60*96+95), 13'(58*96+26),
            13'(58*96+89), 13'(61*96+22), 13'(57*96+20), 13'(58*96+91),
            13'(59*96+12), 13'(53*96+19)};
    exp_o = '{16'hFD46, 16'hF800, 16'h0000, 16'h5A5A,
              16'h0000, 16'h0000, 16'h0000, 16'hABCD,
              16'hC618, 16'hF800, 16'h5A5A, 16'h5A5A,
              16'hFED3, 16'h5A5A};
    bus.menu_en = 1'b1;
    bus.curr_pixel_oled = 16'h5A5A;
    for (int i = 0; i < 14; i++) begin
      bus.pixel_index = pix[i];
      tick();
      vectors++; if (bus.oled_data !== exp_o[i]) begin miscompares++; $display("FAIL overlay_%0d pix=%0d got %h want %h", i, pix[i], bus.oled_data, exp_o[i]); end
    end
    bus.menu_en = 1'b0;
    bus.pixel_index = 13'(58*96+19);
    tick();
    vectors++; if (bus.oled_data !== 16'h5A5A) begin miscompares++; $display("FAIL overlay_menu_off got %h want 5a5a", bus.oled_data); end
    bus.menu_en = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h1111;
    tick();
    bus.wr_en = 1'b0;
    vectors++; if (bus.oled_data !== 16'hFD46) begin miscompares++; $display("FAIL collision_old got %h want fd46", bus.oled_data); end
    tick();
    vectors++; if (bus.oled_data !== 16'h1111) begin miscompares++; $display("FAIL collision_new got %h want 1111", bus.oled_data); end
    vectors++; if (bus.selected_colour !== 16'h1111) begin miscompares++; $display("FAIL collision_selcol got %h want 1111", bus.selected_colour); end
  endtask

  task automatic test_boundary();
    logic [3:0] exp_sel;
    logic       exp_busy;
    bus.menu_en  = 1'b1;
    bus.btn_next = 1'b1;
    repeat (46) tick();
    bus.btn_next = 1'b0;
    vectors++; if (bus.sel_idx !== 4'd12) begin miscompares++; $display("FAIL walk_to_end_sel got %h want c", bus.sel_idx); end
    repeat (4) tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL walk_end_busy got %b want 0", bus.busy); end
    bus.btn_next = 1'b1;
    tick();
    bus.btn_next = 1'b0;
`ifdef PALSEL_WRAP_EN
    exp_sel = 4'd0;  exp_busy = 1'b1;
`else
    exp_sel = 4'd12; exp_busy = 1'b0;
`endif
    vectors++; if (bus.sel_idx !== exp_sel) begin miscompares++; $display("FAIL next_at_end_sel got %h want %h", bus.sel_idx, exp_sel); end
    vectors++; if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL next_at_end_busy got %b want %b", bus.busy, exp_busy); end
    repeat (4) tick();
    vectors++; if (bus.sel_idx !== exp_sel) begin miscompares++; $display("FAIL next_at_end_hold got %h want %h", bus.sel_idx, exp_sel); end
  endtask

  task automatic test_reset_mid_lock();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.menu_en  = 1'b1;
    bus.btn_next = 1'b1;
    repeat (21) tick();
    vectors++; if (bus.sel_idx !== 4'd5) begin miscompares++; $display("FAIL midlock_pre_sel got %h want 5", bus.sel_idx); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midlock_pre_busy got %b want 1", bus.busy); end
    bus.btn_next = 1'b0;
    rstn = 1'b0;
    tick();
    vectors++; if (bus.sel_idx !== 4'd0) begin miscompares++; $display("FAIL midlock_rst_sel got %h want 0", bus.sel_idx); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midlock_rst_busy got %b want 0", bus.busy); end
    vectors++; if (bus.oled_data !== 16'h0000) begin miscompares++; $display("FAIL midlock_rst_oled got %h want 0000", bus.oled_data); end
    rstn = 1'b1;
    bus.btn_next = 1'b1;
    bus.pixel_index = 13'(58*96+19);
    tick();
    bus.btn_next = 1'b0;
    vectors++; if (bus.sel_idx !== 4'd1) begin miscompares++; $display("FAIL post_rst_sel got %h want 1", bus.sel_idx); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL post_rst_busy got %b want 1", bus.busy); end
    vectors++; if (bus.oled_data !== 16'hFD46) begin miscompares++; $display("FAIL post_rst_palette got %h want fd46", bus.oled_data); end
  endtask

  initial begin
    bus.menu_en         = 1'b0;
    bus.btn_next        = 1'b0;
    bus.btn_prev        = 1'b0;
    bus.pixel_index     = '0;
    bus.curr_pixel_oled = '0;
    bus.wr_en           = 1'b0;
    bus.wr_addr         = '0;
    bus.wr_data         = '0;
    test_reset();
    test_hold_repeat();
    test_both_buttons();
    test_write();
    test_overlay();
    test_boundary();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/palette_selector.md
# palette_selector

Parametrised colour-palette selector for the OLED drawing pipeline. It keeps a writable palette of up to 13 RGB565 entries and a cursor over them, moved by next/prev buttons with a hold-off lockout. It draws a swatch strip with a cursor box over the drawing-board pixel stream and exports the selected colour to the paint logic. It sits between the canvas frame store and the OLED driver, and generalises the fixed 13-colour menu with a configurable size, a runtime write port, registered pixel output and optional cursor wrap.

## Interface
Parameters:
- N_COLOURS, 13, number of palette entries; legal range 2..13.
- HOLDOFF, 25_000_000, lockout length in CLOCK cycles after an accepted move; must be ≥1.
- STRIP_Y, 54, top row of the menu strip; the strip occupies rows STRIP_Y..STRIP_Y+9 and must satisfy STRIP_Y ≤ 54.

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge.
- RESETN  in  1  synchronous, active-low reset.
- menu_en  in  1  menu active: enables navigation and strip overlay.
- btn_next  in  1  level; move cursor +1.
- btn_prev  in  1  level; move cursor −1.
- pixel_index  in  13  OLED pixel index, 96×64 raster; x = index mod 96, y = index / 96.
- curr_pixel_oled  in  16  canvas pixel for pixel_index.
- wr_en  in  1  palette write strobe.
- wr_addr  in  4  palette entry to write.
- wr_data  in  16  RGB565 value to write.
- oled_data  out  16  pixel to OLED driver, registered.
- selected_colour  out  16  palette[sel_idx], combinational from registers.
- sel_idx  out  4  cursor position.
- busy  out  1  lockout active.

## Operation
- FSM has two states. IDLE: move requests are accepted. LOCK: a counter runs from 0 to HOLDOFF−1, then the FSM returns to IDLE, and all button input is ignored.
- Move request in IDLE: menu_en=1 and exactly one of btn_next/btn_prev is high. If both buttons are high, nothing happens.
- Accepted move: sel_idx steps by ±1, the counter clears, and the FSM enters LOCK.
- Boundary press: a next at N_COLOURS−1 or a prev at 0 is handled per Configuration. A press that produces no move does not enter LOCK.
- Holding a button gives auto-repeat: one step every HOLDOFF+1 cycles.
- Palette: N_COLOURS×16 registers. Reset values, index 0..12: 0000, FED3, FD46, C240, F800, CB5D, 1619, 2B58, 0C8A, 7687, FFCB, 7BEF, C618.
- Write: wr_en=1 with wr_addr < N_COLOURS writes wr_data on that edge. Writes with wr_addr ≥ N_COLOURS are ignored. Writes are accepted regardless of menu_en or FSM state.
- Overlay geometry (only when menu_en=1), in priority order:
  1. Border: x∈{0,95} or y∈{STRIP_Y, STRIP_Y+9}, within the strip rows → 0000.
  2. Cursor box outline: columns 3+7·sel_idx .. 8+7·sel_idx, rows STRIP_Y+2..STRIP_Y+7 → F800.
  3. Swatch i (i < N_COLOURS): x∈{5+7i, 6+7i}, y∈{STRIP_Y+4, STRIP_Y+5} → palette[i].
  4. Everything else → curr_pixel_oled.
- Unselected box outlines are not drawn.
- When menu_en=0, oled_data carries curr_pixel_oled.

## Timing
- Reset (RESETN=0 at a CLOCK edge) gives:
  - sel_idx=0, state IDLE, counter=0, busy=0
  - palette at its reset values
  - oled_data=0000, selected_colour=0000
- Reset mid-LOCK aborts the lockout immediately.
- oled_data latency: 1 cycle from pixel_index/curr_pixel_oled.
- Render/write collision: a palette write and a render of the same swatch in the same cycle output the old value. The new value appears from the next cycle.
- sel_idx updates on the edge that accepts the move. busy is high from the next cycle for exactly HOLDOFF cycles.
- selected_colour reflects sel_idx and palette changes in the same cycle as the register update.
- menu_en falling during LOCK: the lockout still completes.

## Configuration
- PALSEL_WRAP_EN defined: next at N_COLOURS−1 moves to 0, and prev at 0 moves to N_COLOURS−1. Each wrap is an accepted move and enters LOCK.
- PALSEL_WRAP_EN undefined: the cursor saturates. A boundary press changes nothing and does not enter LOCK.

## Test plan
- HOLDOFF=4, reset, then btn_next held for 12 cycles → sel_idx goes 0→1→2→3, one step every 5 cycles; busy high 4 cycles after each step.
- sel_idx=12, N_COLOURS=13, btn_next pulse → with PALSEL_WRAP_EN: sel_idx=0 and busy rises. Without it: sel_idx stays 12 and busy stays 0.
- btn_next and btn_prev both high in IDLE → sel_idx unchanged, busy=0.
- wr_en with wr_addr=3, wr_data=ABCD at sel_idx=3 → selected_colour=ABCD on the next cycle. wr_addr=13 with N_COLOURS=13 → no palette change.
- menu_en=1, sel_idx=2, STRIP_Y=54:
  - pixel_index=58·96+19 → oled_data=FD46 one cycle later
  - 56·96+17 → F800
  - 54·96+40 → 0000
  - 10·96+10 → curr_pixel_oled
- RESETN low mid-LOCK with sel_idx=5 → next cycle sel_idx=0, busy=0, oled_data=0000, and a btn_next press is accepted immediately after reset is released.
